// File: rtl/aes_pkg.sv
// Shared constants, FSM state type and GF(2^8) arithmetic for the AES-128 inverse cipher.
package aes_pkg;

  localparam int NR       = 10;
  localparam int BLK_W    = 128;
  localparam int KSCHED_W = BLK_W * (NR + 1);
  localparam int CNT_W    = $clog2(NR + 1);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] a);
    return gmul(a, 8'h09);
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] a);
    return gmul(a, 8'h0b);
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] a);
    return gmul(a, 8'h0d);
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] a);
    return gmul(a, 8'h0e);
  endfunction

  // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gmul(a, a);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  // Inverse affine transform followed by field inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [0:BLK_W-1] state_in,
  input  logic [0:BLK_W-1] rkey,
  input  logic             last,
  output logic [0:BLK_W-1] state_out
);

  logic [7:0] sb [16];
  logic [7:0] ak [16];

  // Byte index is 4*column + row; row r is rotated right by r columns.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sb[4*c + r] = inv_sbox(state_in[8*(4*((c - r + 4) % 4) + r) +: 8]);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      ak[i] = sb[i] ^ rkey[8*i +: 8];
    end
  end

  always_comb begin
    state_out = '0;
    for (int c = 0; c < 4; c++) begin
      if (last) begin
        for (int r = 0; r < 4; r++) begin
          state_out[8*(4*c + r) +: 8] = ak[4*c + r];
        end
      end else begin
        state_out[32*c      +: 8] = gmul14(ak[4*c]) ^ gmul11(ak[4*c+1]) ^ gmul13(ak[4*c+2]) ^ gmul9(ak[4*c+3]);
        state_out[32*c + 8  +: 8] = gmul9(ak[4*c])  ^ gmul14(ak[4*c+1]) ^ gmul11(ak[4*c+2]) ^ gmul13(ak[4*c+3]);
        state_out[32*c + 16 +: 8] = gmul13(ak[4*c]) ^ gmul9(ak[4*c+1])  ^ gmul14(ak[4*c+2]) ^ gmul11(ak[4*c+3]);
        state_out[32*c + 24 +: 8] = gmul11(ak[4*c]) ^ gmul13(ak[4*c+1]) ^ gmul9(ak[4*c+2])  ^ gmul14(ak[4*c+3]);
      end
    end
  end

endmodule

// File: rtl/aes_inv_rounds.sv
// Iterative AES-128 inverse cipher, one inverse round per clock, valid/ready on both sides.
//   state | meaning
//   IDLE  | waiting for a ciphertext block, in_ready high
//   ROUND | applying inverse rounds, round_cnt counts down to 0
//   DONE  | plaintext held in out_data until out_ready
module aes_inv_rounds
  import aes_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [0:KSCHED_W-1] schedule,
  input  logic [0:BLK_W-1]    in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [0:BLK_W-1]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  state_t           state;
  logic [CNT_W-1:0] round_cnt;
  logic [0:BLK_W-1] state_reg;
  logic [0:BLK_W-1] rk [NR+1];
  logic [0:BLK_W-1] rkey;
  logic [0:BLK_W-1] round_out;
  logic [0:BLK_W-1] init_state;

  for (genvar k = 0; k <= NR; k++) begin : g_rk
    assign rk[k] = schedule[BLK_W*k +: BLK_W];
  end

  assign rkey       = rk[round_cnt];
  assign init_state = in_data ^ rk[NR];
  assign in_ready   = (state == IDLE) || ((state == DONE) && out_ready);
  assign busy       = (state == ROUND);

  aes_inv_round u_round (
    .state_in  (state_reg),
    .rkey      (rkey),
    .last      (round_cnt == '0),
    .state_out (round_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      round_cnt <= '0;
      state_reg <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state_reg <= init_state;
            round_cnt <= CNT_W'(NR - 1);
            state     <= ROUND;
          end
        end
        ROUND: begin
          if (round_cnt == '0) begin
            out_data  <= round_out;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            state_reg <= round_out;
            round_cnt <= round_cnt - 1'b1;
          end
        end
        DONE: begin
          // Consuming the result and accepting the next block can share one edge.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              state_reg <= init_state;
              round_cnt <= CNT_W'(NR - 1);
              state     <= ROUND;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_rounds.sv
// Bench for aes_inv_rounds: FIPS-197 vectors through a scoreboard plus handshake corner cases.
module tb_aes_inv_rounds;

  logic          tb_clk = 1'b0;
  logic          rst;
  logic [0:1407] schedule;
  logic [0:127]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [0:127]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  always #5 tb_clk = ~tb_clk;

  aes_inv_rounds dut (
    .clk       (tb_clk),
    .rst       (rst),
    .schedule  (schedule),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t          vecs   [3];
  logic [0:1407] scheds [3];
  logic [127:0]  sb_q [$];
  logic [127:0]  sb_exp;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;

  always @(posedge tb_clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] tb_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = tb_xtime(x);
    end
    return p;
  endfunction

  // Forward S-box: brute-force field inverse, then the forward affine map.
  function automatic logic [7:0] tb_sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int x = 1; x < 256; x++) begin
      if (tb_gmul(a, 8'(x)) == 8'h01) inv = 8'(x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [0:1407] expand_key(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [0:1407] s;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {tb_sbox(t[31:24]), tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0])} ^ {rc, 24'h0};
        rc = tb_xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) s[32*i +: 32] = w[i];
    return s;
  endfunction

  // Scoreboard: every handshake on the output side must match the oldest expected plaintext.
  always @(negedge tb_clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: got output %0h expected none", out_data);
      end else begin
        sb_exp = sb_q.pop_front();
        check("sb_data", out_data, sb_exp);
      end
    end
  end

  // Called just after a rising edge; returns just after the acceptance edge.
  task automatic send(input int idx, output int acc_cyc);
    int n;
    n       = 0;
    acc_cyc = -1;
    in_data  = vecs[idx].ct;
    schedule = scheds[idx];
    in_valid = 1'b1;
    while (acc_cyc < 0 && n < 40) begin
      @(negedge tb_clk);
      if (in_ready) begin
        sb_q.push_back(vecs[idx].pt);
        acc_cyc = cyc + 1;
      end
      @(posedge tb_clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (acc_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
    end
  endtask

  task automatic wait_valid(input int limit, output int at_cyc);
    int n;
    n      = 0;
    at_cyc = -1;
    while (at_cyc < 0 && n < limit) begin
      @(negedge tb_clk);
      if (out_valid) at_cyc = cyc;
      n++;
    end
    if (at_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: got out_valid=0 for %0d cycles expected 1", n);
    end
  endtask

  task automatic wait_empty(input int limit);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < limit) begin
      @(negedge tb_clk);
      n++;
    end
    check("sb_drained", 128'(sb_q.size()), 128'd0);
    @(posedge tb_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int at;
    int c0;
    logic [127:0] held;

    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734};
    vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
    vecs[2] = '{128'h00000000000000000000000000000000, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h00000000000000000000000000000000};
    for (int i = 0; i < 3; i++) scheds[i] = expand_key(vecs[i].key);

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    schedule  = '0;
    repeat (3) @(posedge tb_clk);
    @(negedge tb_clk);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    @(posedge tb_clk);
    #1 rst = 1'b0;
    @(negedge tb_clk);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    @(posedge tb_clk);
    #1;

    // Appendix B with latency, then 20 cycles of backpressure.
    send(0, acc);
    wait_valid(30, at);
    check("lat_b", 128'(at - acc), 128'd10);
    check("pt_b", out_data, vecs[0].pt);
    held = out_data;
    for (int i = 0; i < 20; i++) begin
      @(negedge tb_clk);
      check("bp_valid", 128'(out_valid), 128'd1);
      check("bp_data", out_data, held);
      check("bp_in_ready", 128'(in_ready), 128'd0);
      check("bp_busy", 128'(busy), 128'd0);
    end
    @(posedge tb_clk);
    #1 out_ready = 1'b1;
    @(posedge tb_clk);
    #1 out_ready = 1'b0;
    @(negedge tb_clk);
    check("bp_release_valid", 128'(out_valid), 128'd0);
    check("bp_release_ready", 128'(in_ready), 128'd1);
    @(posedge tb_clk);
    #1;

    // Vector table with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(i, acc);
      wait_valid(30, at);
      check("lat_table", 128'(at - acc), 128'd10);
      wait_empty(5);
    end

    // Back-to-back: C.1 accepted on the same edge that hands off the Appendix B result.
    out_ready = 1'b0;
    send(0, acc);
    wait_valid(30, at);
    @(posedge tb_clk);
    #1;
    out_ready = 1'b1;
    c0 = cyc;
    send(1, acc);
    check("b2b_accept", 128'(acc - c0), 128'd1);
    @(negedge tb_clk);
    check("b2b_valid_drop", 128'(out_valid), 128'd0);
    check("b2b_busy", 128'(busy), 128'd1);
    wait_valid(30, at);
    check("b2b_lat", 128'(at - acc), 128'd10);
    wait_empty(5);

    // Asynchronous reset with round_cnt at 5 aborts the block.
    send(0, acc);
    repeat (4) @(posedge tb_clk);
    #1;
    check("mid_busy", 128'(busy), 128'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 128'(out_valid), 128'd0);
    check("mid_rst_data", out_data, 128'd0);
    check("mid_rst_busy", 128'(busy), 128'd0);
    sb_q.delete();
    @(posedge tb_clk);
    #1 rst = 1'b0;
    @(negedge tb_clk);
    check("mid_rst_in_ready", 128'(in_ready), 128'd1);
    @(posedge tb_clk);
    #1;
    send(0, acc);
    wait_valid(30, at);
    check("post_rst_lat", 128'(at - acc), 128'd10);
    wait_empty(5);

    // Garbage on in_valid/in_data while busy must be ignored.
    send(1, acc);
    for (int i = 0; i < 6; i++) begin
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      in_valid = (i % 3 != 2);
      @(negedge tb_clk);
      check("ign_in_ready", 128'(in_ready), 128'd0);
      check("ign_busy", 128'(busy), 128'd1);
      @(posedge tb_clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = '0;
    wait_valid(30, at);
    check("ign_lat", 128'(at - acc), 128'd10);
    wait_empty(5);

    repeat (15) @(negedge tb_clk);
    check("final_empty", 128'(sb_q.size()), 128'd0);
    check("final_idle_valid", 128'(out_valid), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
